// File: rtl/dispatch_scheduler.sv
// dispatch_scheduler: sequencer for the activation/weight dispatcher.
// Fills its ping-pong buffer from the upstream stream, issues reads
// toward the PE array, latches broadcast modes and counts done pulses.
// Optional macro SCHED_TIMEOUT_EN adds a DRAIN watchdog that sets error.
// Ports:
//   clk, rst                     clock, sync active-high reset
//   start, num_tiles, cfg_*      job start and per-job config
//   src_valid / src_ready        upstream word handshake
//   pe_ready                     PE array can take a dispatch
//   disp_wen, disp_*_write_addr  buffer write strobe and slot
//   disp_en, disp_*_read_addr    buffer read strobe and slot
//   disp_a_mode, disp_w_mode     latched broadcast modes
//   disp_done                    dispatcher done pulse per read
//   busy, done_all, tile_count   job status
//   error                        sticky watchdog error
module dispatch_scheduler #(
    parameter int ADDR_W      = 6,
    parameter int BUF_DEPTH   = 2,
    parameter int TILE_W      = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [TILE_W-1:0] num_tiles,
    input  logic [1:0]        cfg_a_mode,
    input  logic [1:0]        cfg_w_mode,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic              pe_ready,
    output logic              disp_wen,
    output logic [ADDR_W-1:0] disp_w_write_address,
    output logic [ADDR_W-1:0] disp_a_write_address,
    output logic              disp_en,
    output logic [ADDR_W-1:0] disp_w_read_address,
    output logic [ADDR_W-1:0] disp_a_read_address,
    output logic [1:0]        disp_a_mode,
    output logic [1:0]        disp_w_mode,
    input  logic              disp_done,
    output logic              busy,
    output logic              done_all,
    output logic [TILE_W-1:0] tile_count,
    output logic              error
);

    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BUF_DEPTH - 1);
    localparam logic [OCC_W-1:0]  FULL = OCC_W'(BUF_DEPTH);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [OCC_W-1:0]  occ;
    logic [TILE_W-1:0] num_q;
    logic [TILE_W-1:0] wr_cnt;
    logic [TILE_W-1:0] rd_cnt;
    logic [TILE_W-1:0] done_cnt;
    logic [1:0]        a_mode_q;
    logic [1:0]        w_mode_q;
    logic              in_run;
    logic              wr_ok;
    logic              rd_ok;
    logic              done_hit;
    logic              wd_hit;

    assign in_run = (state == RUN);
    assign wr_ok  = in_run && (occ < FULL) && (wr_cnt < num_q);
    // A write owns the cycle, so a read is only offered when no write fires.
    assign rd_ok  = in_run && (occ != '0) && pe_ready && !(src_valid && wr_ok);

    assign src_ready            = wr_ok;
    assign disp_wen             = src_valid && wr_ok;
    assign disp_w_write_address = wr_ptr;
    assign disp_a_write_address = wr_ptr;
    assign disp_en              = rd_ok;
    assign disp_w_read_address  = rd_ptr;
    assign disp_a_read_address  = rd_ptr;
    assign disp_a_mode          = a_mode_q;
    assign disp_w_mode          = w_mode_q;
    assign busy                 = (state != IDLE);
    assign done_all             = (state == FINISH);
    assign tile_count           = done_cnt;
    assign done_hit = disp_done && (in_run || state == DRAIN);

`ifdef SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            err_q;

    // Counts DRAIN cycles since the last disp_done.
    assign wd_hit = (state == DRAIN) && !disp_done &&
                    (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
    assign error  = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state != DRAIN || disp_done)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + 1'b1;
            if (wd_hit)
                err_q <= 1'b1;
        end
    end
`else
    assign wd_hit = 1'b0;
    assign error  = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:
                if (start)
                    state_nxt = (num_tiles == '0) ? FINISH : RUN;
            RUN:
                if (rd_cnt == num_q)
                    state_nxt = DRAIN;
            DRAIN:
                if (done_cnt == num_q || wd_hit)
                    state_nxt = FINISH;
            default:
                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            num_q    <= '0;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            done_cnt <= '0;
            a_mode_q <= '0;
            w_mode_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                num_q    <= num_tiles;
                a_mode_q <= cfg_a_mode;
                w_mode_q <= cfg_w_mode;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                occ      <= '0;
                wr_cnt   <= '0;
                rd_cnt   <= '0;
                done_cnt <= '0;
            end else begin
                if (disp_wen) begin
                    wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
                    wr_cnt <= wr_cnt + 1'b1;
                    occ    <= occ + 1'b1;
                end
                // Slot is released at the edge where the dispatcher
                // captures its read data.
                if (disp_en) begin
                    rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
                    rd_cnt <= rd_cnt + 1'b1;
                    occ    <= occ - 1'b1;
                end
                if (done_hit)
                    done_cnt <= done_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dispatch_scheduler.sv
// tb_dispatch_scheduler: scoreboard bench for dispatch_scheduler.
// Expected strobe/slot sequences are queued per job and matched in order.
module tb_dispatch_scheduler;

    localparam int ADDR_W = 6;
    localparam int TILE_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [TILE_W-1:0] num_tiles;
    logic [1:0]        cfg_a_mode;
    logic [1:0]        cfg_w_mode;
    logic              src_valid;
    logic              src_ready;
    logic              pe_ready;
    logic              disp_wen;
    logic [ADDR_W-1:0] disp_w_write_address;
    logic [ADDR_W-1:0] disp_a_write_address;
    logic              disp_en;
    logic [ADDR_W-1:0] disp_w_read_address;
    logic [ADDR_W-1:0] disp_a_read_address;
    logic [1:0]        disp_a_mode;
    logic [1:0]        disp_w_mode;
    logic              disp_done;
    logic              busy;
    logic              done_all;
    logic [TILE_W-1:0] tile_count;
    logic              error;

    dispatch_scheduler dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .num_tiles            (num_tiles),
        .cfg_a_mode           (cfg_a_mode),
        .cfg_w_mode           (cfg_w_mode),
        .src_valid            (src_valid),
        .src_ready            (src_ready),
        .pe_ready             (pe_ready),
        .disp_wen             (disp_wen),
        .disp_w_write_address (disp_w_write_address),
        .disp_a_write_address (disp_a_write_address),
        .disp_en              (disp_en),
        .disp_w_read_address  (disp_w_read_address),
        .disp_a_read_address  (disp_a_read_address),
        .disp_a_mode          (disp_a_mode),
        .disp_w_mode          (disp_w_mode),
        .disp_done            (disp_done),
        .busy                 (busy),
        .done_all             (done_all),
        .tile_count           (tile_count),
        .error                (error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int wen_seen = 0;
    int done_seen = 0;
    int sb[$];

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Dispatcher model: done pulse two cycles after each read strobe.
    logic [1:0] en_d;
    always @(posedge clk) begin
        if (rst)
            en_d <= 2'b00;
        else
            en_d <= {en_d[0], disp_en};
    end
    assign disp_done = en_d[1];

    // Strobe monitor: exclusivity, address pairing, in-order scoreboard.
    always @(negedge clk) begin
        if (disp_wen || disp_en) begin
            int obs;
            check("excl", 64'(disp_wen & disp_en), 64'd0);
            if (disp_en) begin
                obs = 256 + int'(disp_w_read_address);
                check("rd_addr_eq", 64'(disp_a_read_address),
                      64'(disp_w_read_address));
            end else begin
                obs = int'(disp_w_write_address);
                check("wr_addr_eq", 64'(disp_a_write_address),
                      64'(disp_w_write_address));
            end
            if (disp_wen)
                wen_seen++;
            if (sb.size() == 0)
                check("sb_extra", 64'(obs), 64'hFFFF);
            else
                check("sb_order", 64'(obs), 64'(sb.pop_front()));
        end
        if (done_all)
            done_seen++;
    end

    function automatic logic [63:0] all_outs();
        return 64'({src_ready, disp_wen, disp_w_write_address,
                    disp_a_write_address, disp_en, disp_w_read_address,
                    disp_a_read_address, disp_a_mode, disp_w_mode,
                    busy, done_all, tile_count, error});
    endfunction

    // Wait (bounded) for done_all; checks tile_count at the pulse.
    task automatic wait_done(string tag, int exp_tiles, bit chk_mode,
                             logic [1:0] am, logic [1:0] wm);
        bit got = 0;
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge clk);
            if (chk_mode) begin
                check({tag, "_amode"}, 64'(disp_a_mode), 64'(am));
                check({tag, "_wmode"}, 64'(disp_w_mode), 64'(wm));
            end
            if (done_all) begin
                got = 1;
                check({tag, "_tiles"}, 64'(tile_count), 64'(exp_tiles));
            end
            step();
            if (i == 2) begin
                cfg_a_mode = 2'b00;
                cfg_w_mode = 2'b00;
            end
        end
        if (!got)
            check({tag, "_timeout"}, 64'd0, 64'd1);
        check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int base;
        rst        = 1'b1;
        start      = 1'b0;
        num_tiles  = '0;
        cfg_a_mode = 2'b00;
        cfg_w_mode = 2'b00;
        src_valid  = 1'b0;
        pe_ready   = 1'b0;
        repeat (2) step();
        @(negedge clk);
        check("reset_outs", all_outs(), 64'd0);
        step();
        rst = 1'b0;

        // Zero-tile job: one FINISH cycle, no strobes.
        start     = 1'b1;
        num_tiles = 16'd0;
        step();
        start = 1'b0;
        @(negedge clk);
        check("zero_busy", 64'(busy), 64'd1);
        check("zero_done", 64'(done_all), 64'd1);
        step();
        @(negedge clk);
        check("zero_idle", 64'(busy), 64'd0);
        check("zero_done_low", 64'(done_all), 64'd0);

        // Four tiles, streams held high; cfg changed mid-job.
        sb = '{0, 1, 256, 0, 257, 1, 256, 257};
        step();
        num_tiles  = 16'd4;
        cfg_a_mode = 2'b11;
        cfg_w_mode = 2'b01;
        src_valid  = 1'b1;
        pe_ready   = 1'b1;
        start      = 1'b1;
        step();
        start = 1'b0;
        wait_done("t4", 4, 1'b1, 2'b11, 2'b01);
        @(negedge clk);
        check("t4_idle", 64'(busy), 64'd0);
        check("t4_hold_a", 64'(disp_a_mode), 64'd3);
        check("t4_hold_w", 64'(disp_w_mode), 64'd1);

        // Reset after two writes of a five-tile job.
        sb = '{0, 1};
        step();
        num_tiles = 16'd5;
        pe_ready  = 1'b0;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        @(negedge clk);
        check("rst_full", 64'(src_ready), 64'd0);
        step();
        rst = 1'b1;
        base = done_seen;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_outs", all_outs(), 64'd0);
        repeat (4) step();
        check("midrst_nodone", 64'(done_seen), 64'(base));
        check("midrst_sb", 64'(sb.size()), 64'd0);

        // Three tiles with pe_ready held low: buffer fills, then drains.
        sb = '{0, 1, 256, 0, 257, 256};
        base = wen_seen;
        num_tiles = 16'd3;
        src_valid = 1'b1;
        pe_ready  = 1'b0;
        start     = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        @(negedge clk);
        check("full_ready", 64'(src_ready), 64'd0);
        check("full_writes", 64'(wen_seen - base), 64'd2);
        check("full_busy", 64'(busy), 64'd1);
        step();
        pe_ready = 1'b1;
        wait_done("t3", 3, 1'b0, 2'b00, 2'b00);
        @(negedge clk);
        check("t3_idle", 64'(busy), 64'd0);
        check("t3_err", 64'(error), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
